// File: rtl/kb_scan_dev.sv
// 4x4 matrix keypad scanner with single-key debounce and a bus-readable event FIFO.
// Define KB_RELEASE_EVT_EN to also queue key-release events (bit 4 set).
module kb_scan_dev #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IO_BUS_WIDTH_DATA = 32,
    localparam int unsigned DEVICE_NUM_KB_ROW = 4,
    localparam int unsigned DEVICE_NUM_KB_COL = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sel,
    input  logic                         we,
    input  logic [3:0]                   addr,
    input  logic [IO_BUS_WIDTH_DATA-1:0] wdata,
    output logic [IO_BUS_WIDTH_DATA-1:0] rdata,
    output logic [DEVICE_NUM_KB_ROW-1:0] row_en,
    input  logic [DEVICE_NUM_KB_COL-1:0] col_signal
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EVT_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_DEB, S_HELD, S_REL} state_t;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic             r_hit;
    logic [3:0]       r_code;
    logic             r_seen;
    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [3:0]       r_cand;
    logic [EVT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;

    logic             w_sample;
    logic             w_eos;
    logic [3:0]       w_low;
    logic [1:0]       w_first_col;
    logic             w_new_scan;
    logic             w_scan_hit;
    logic [3:0]       w_scan_code;
    logic             w_scan_seen;
    logic [3:0]       w_cnt_inc;
    logic             w_cnt_done;
    logic             w_push;
    logic [EVT_W-1:0] w_push_evt;
    logic             w_rd;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_store;
    logic             w_ovf_set;
    logic             w_ovf_clr;
    logic             w_unused_wdata;

    assign w_sample   = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_eos      = w_sample && (r_row == 2'd3);
    assign w_low      = ~col_signal;
    assign w_new_scan = (r_row == 2'd0);

    // Lowest-numbered low column in the active row
    always_comb begin
        w_first_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (w_low[c]) w_first_col = 2'(c);
        end
    end

    // Scan results including the row being sampled this cycle
    assign w_scan_hit  = (!w_new_scan && r_hit) || (|w_low);
    assign w_scan_code = (!w_new_scan && r_hit) ? r_code : {r_row, w_first_col};
    assign w_scan_seen = (!w_new_scan && r_seen) ||
                         ((r_cand[3:2] == r_row) && w_low[r_cand[1:0]]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_row  <= 2'd0;
            row_en <= 4'b1110;
            r_hit  <= 1'b0;
            r_code <= 4'd0;
            r_seen <= 1'b0;
        end else if (w_sample) begin
            r_div  <= '0;
            r_row  <= r_row + 2'd1;
            row_en <= ~(4'b0001 << 2'(r_row + 2'd1));
            r_hit  <= w_scan_hit;
            r_code <= w_scan_code;
            r_seen <= w_scan_seen;
        end else begin
            r_div  <= r_div + DIV_W'(1);
        end
    end

    assign w_cnt_inc  = r_cnt + 4'd1;
    assign w_cnt_done = (w_cnt_inc == 4'(DEBOUNCE));

    // Event generation on end-of-scan transitions
    always_comb begin
        w_push     = 1'b0;
        w_push_evt = '0;
        if (w_eos) begin
            case (r_state)
                S_IDLE: if (w_scan_hit && DEBOUNCE == 1) begin
                    w_push     = 1'b1;
                    w_push_evt = {1'b0, w_scan_code};
                end
                S_DEB: if (w_scan_seen && w_cnt_done) begin
                    w_push     = 1'b1;
                    w_push_evt = {1'b0, r_cand};
                end
`ifdef KB_RELEASE_EVT_EN
                S_HELD: if (!w_scan_seen && DEBOUNCE == 1) begin
                    w_push     = 1'b1;
                    w_push_evt = {1'b1, r_cand};
                end
                S_REL: if (!w_scan_seen && w_cnt_done) begin
                    w_push     = 1'b1;
                    w_push_evt = {1'b1, r_cand};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_cand  <= 4'd0;
        end else if (w_eos) begin
            case (r_state)
                S_IDLE: if (w_scan_hit) begin
                    r_cand  <= w_scan_code;
                    r_cnt   <= 4'd1;
                    r_state <= (DEBOUNCE == 1) ? S_HELD : S_DEB;
                end
                S_DEB: if (w_scan_seen) begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_done) r_state <= S_HELD;
                end else begin
                    r_state <= S_IDLE;
                end
                S_HELD: if (!w_scan_seen) begin
                    r_cnt   <= 4'd1;
                    r_state <= (DEBOUNCE == 1) ? S_IDLE : S_REL;
                end
                S_REL: if (w_scan_seen) begin
                    r_state <= S_HELD;
                end else begin
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rd      = sel && !we;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = w_rd && (addr == 4'h0) && !w_empty;
    assign w_store   = w_push && (!w_full || w_pop);
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_ovf_clr = sel && we && (addr == 4'h4) && wdata[8];
    assign w_unused_wdata = ^{wdata[IO_BUS_WIDTH_DATA-1:9], wdata[7:0]};

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wptr] <= w_push_evt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_store) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)   r_rptr <= r_rptr + PTR_W'(1);
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
            // Set has priority over a same-cycle clear
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (w_rd) begin
            case (addr)
                4'h0:    rdata <= w_empty ? '0 : {1'b1, 26'b0, r_mem[r_rptr]};
                4'h4:    rdata <= {23'b0, r_ovf, 3'b0, 5'(r_count)};
                default: rdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_scan_dev.sv
// Scoreboard bench for kb_scan_dev: a keypad model drives the columns, reads queue expectations.
module tb_kb_scan_dev;

    localparam int unsigned SCAN_DIV   = 4;
    localparam int unsigned DEBOUNCE   = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  row_en;
    logic [3:0]  col_signal;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_q = 1'b0;
    logic [31:0] mon_exp;
    string       mon_name;

    always #5 clk = ~clk;

    kb_scan_dev #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE   (DEBOUNCE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sel        (sel),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .row_en     (row_en),
        .col_signal (col_signal)
    );

    // Keypad matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_signal = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_en[r]) col_signal = ~keys[r*4 +: 4];
        end
    end

    always @(posedge clk) rd_q <= sel && !we;

    always @(negedge clk) begin
        if (rd_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got 0x%08h with no expectation", rdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (rdata !== mon_exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name, rdata, mon_exp);
                end
            end
        end
    end

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string n);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
        sel  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel   = 1'b0;
        we    = 1'b0;
    endtask

    // Returns at the negedge of the first cycle of the next scan (row 0, divider 0)
    task automatic scan_start();
        logic [3:0] prev;
        logic       found;
        prev  = row_en;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (prev == 4'b0111 && row_en == 4'b1110) found = 1'b1;
            prev = row_en;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL scan_align: row_en=%b never wrapped to row 0", row_en);
        end
    endtask

    task automatic press_release(input int k, input int ps, input int rs);
        scan_start();
        keys = 16'(1) << k;
        repeat (ps) scan_start();
        keys = 16'h0;
        repeat (rs) scan_start();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_row;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = 32'h0;
        keys  = 16'h0;
        rst   = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b0;

        // Row drive rotates every SCAN_DIV cycles starting at row 0
        for (int i = 0; i < 16; i++) begin
            exp_row = ~(4'b0001 << (i / 4));
            checks++;
            if (row_en !== exp_row) begin
                errors++;
                $display("FAIL row_en_cycle%0d: got %b expected %b", i, row_en, exp_row);
            end
            @(negedge clk);
        end
        rd(4'h4, 32'h0000_0000, "status_reset");
        rd(4'h0, 32'h0000_0000, "data_reset");
        rd(4'h8, 32'h0000_0000, "other_offset");

        // Key 6 held three scans
        press_release(6, 3, 0);
        rd(4'h4, 32'h0000_0001, "key6_status");
        rd(4'h0, 32'h8000_0006, "key6_data");
        rd(4'h4, 32'h0000_0000, "key6_status_after");
        repeat (3) scan_start();
`ifdef KB_RELEASE_EVT_EN
        rd(4'h0, 32'h8000_0016, "key6_release");
`endif
        rd(4'h0, 32'h0000_0000, "key6_empty");

        // One-scan glitch must not queue anything and must leave the tracker idle
        press_release(5, 1, 2);
        rd(4'h4, 32'h0000_0000, "glitch_status");
        press_release(9, 3, 3);
        rd(4'h0, 32'h8000_0009, "key9_press");
`ifdef KB_RELEASE_EVT_EN
        rd(4'h0, 32'h8000_0019, "key9_release");
`endif
        rd(4'h4, 32'h0000_0000, "key9_status");

        // Overflow: five press/release cycles without reads
        for (int k = 1; k <= 5; k++) press_release(k, 2, 2);
        rd(4'h4, 32'h0000_0104, "ovf_status");
        wr(4'h4, 32'h0000_0000);
        rd(4'h4, 32'h0000_0104, "ovf_noclear");
        wr(4'h0, 32'h0000_0100);
        rd(4'h4, 32'h0000_0104, "ovf_data_write");
        wr(4'h4, 32'h0000_0100);
        rd(4'h4, 32'h0000_0004, "ovf_cleared");
`ifdef KB_RELEASE_EVT_EN
        rd(4'h0, 32'h8000_0001, "ovf_q0");
        rd(4'h0, 32'h8000_0011, "ovf_q1");
        rd(4'h0, 32'h8000_0002, "ovf_q2");
        rd(4'h0, 32'h8000_0012, "ovf_q3");
`else
        rd(4'h0, 32'h8000_0001, "ovf_q0");
        rd(4'h0, 32'h8000_0002, "ovf_q1");
        rd(4'h0, 32'h8000_0003, "ovf_q2");
        rd(4'h0, 32'h8000_0004, "ovf_q3");
`endif
        rd(4'h4, 32'h0000_0000, "ovf_drained");

        // Full FIFO: DATA read lands on the EOS cycle that pushes key 7
`ifdef KB_RELEASE_EVT_EN
        for (int k = 1; k <= 2; k++) press_release(k, 2, 2);
`else
        for (int k = 1; k <= 4; k++) press_release(k, 2, 2);
`endif
        rd(4'h4, 32'h0000_0004, "fill_status");
        scan_start();
        keys = 16'(1) << 7;
        scan_start();
        repeat (15) @(negedge clk);
        rd(4'h0, 32'h8000_0001, "coincide_pop");
        rd(4'h4, 32'h0000_0004, "coincide_status");
`ifdef KB_RELEASE_EVT_EN
        rd(4'h0, 32'h8000_0011, "coincide_q1");
        rd(4'h0, 32'h8000_0002, "coincide_q2");
        rd(4'h0, 32'h8000_0012, "coincide_q3");
`else
        rd(4'h0, 32'h8000_0002, "coincide_q1");
        rd(4'h0, 32'h8000_0003, "coincide_q2");
        rd(4'h0, 32'h8000_0004, "coincide_q3");
`endif
        rd(4'h0, 32'h8000_0007, "coincide_newest");
        rd(4'h4, 32'h0000_0000, "coincide_drained");
        keys = 16'h0;

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
